// File: rtl/arb_pkg.sv
// Shared types and parameter defaults for the rd_arbiter read-device arbiter.
package arb_pkg;

    localparam int ARB_NREQ_DEF = 4;
    localparam int ARB_WAIT_DEF = 2;
    localparam int ARB_TO_DEF   = 15;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        DLY  = 2'd2,
        DONE = 2'd3
    } arb_state_e;

endpackage

// File: rtl/rd_arbiter_rr_pick.sv
// rr_pick: combinational wrap-around priority search, first set req bit at or above ptr.
module rr_pick
    import arb_pkg::*;
#(
    parameter int NREQ = ARB_NREQ_DEF
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] ptr,
    output logic [NREQ-1:0]         win
);

    localparam int PW = $clog2(NREQ);

    logic [PW:0] w_pos;
    logic        w_found;

    always_comb begin
        win     = '0;
        w_pos   = '0;
        w_found = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            // ptr < NREQ, so one subtraction brings the offset back into range
            w_pos = {1'b0, ptr} + (PW+1)'(i);
            if (w_pos >= (PW+1)'(NREQ))
                w_pos = w_pos - (PW+1)'(NREQ);
            if (!w_found && req[w_pos[PW-1:0]]) begin
                win[w_pos[PW-1:0]] = 1'b1;
                w_found            = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rd_arbiter.sv
// rd_arbiter: round-robin arbiter for a shared read device (IDLE/READ/DLY/DONE).
// Optional READ timeout enabled by defining RD_ARBITER_TIMEOUT_EN.
module rd_arbiter
    import arb_pkg::*;
#(
    parameter int NREQ     = ARB_NREQ_DEF,
    parameter int WAIT_CYC = ARB_WAIT_DEF,
    parameter int TO_CYC   = ARB_TO_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] gnt,
    output logic [NREQ-1:0] done,
    input  logic            ack,
    output logic            rd,
    output logic            ds,
    output logic            err
);

    localparam int PW = $clog2(NREQ);

    arb_state_e      r_state;
    arb_state_e      w_nxt;
    logic [PW-1:0]   r_ptr;
    logic [PW-1:0]   w_gnt_idx;
    logic [PW-1:0]   w_ptr_nxt;
    logic [NREQ-1:0] w_win;
    logic [NREQ-1:0] r_gnt;
    logic [NREQ-1:0] r_done;
    logic            r_rd;
    logic            r_ds;
    logic [3:0]      r_dly;
    logic            w_to_hit;

`ifdef RD_ARBITER_TIMEOUT_EN
    logic [7:0]      r_to;
    logic            r_err;
    assign w_to_hit = (r_to == 8'(TO_CYC));
    assign err      = r_err;
`else
    assign w_to_hit = 1'b0;
    assign err      = 1'b0;
`endif

    rr_pick #(.NREQ(NREQ)) u_pick (
        .req (req),
        .ptr (r_ptr),
        .win (w_win)
    );

    always_comb begin
        w_gnt_idx = '0;
        for (int i = 0; i < NREQ; i++)
            if (r_gnt[i]) w_gnt_idx = PW'(i);
    end

    assign w_ptr_nxt = (w_gnt_idx == PW'(NREQ-1)) ? '0 : w_gnt_idx + 1'b1;

    always_comb begin
        w_nxt = arb_state_e'(2'bxx);
        case (r_state)
            IDLE:    w_nxt = (|req) ? READ : IDLE;
            READ:    w_nxt = ack ? DLY : (w_to_hit ? DONE : READ);
            DLY:     w_nxt = (r_dly == 4'd0) ? DONE : DLY;
            DONE:    w_nxt = IDLE;
            default: ;
        endcase
    end

    // Outputs are decoded from w_nxt so they switch on the same edge as the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_gnt   <= '0;
            r_done  <= '0;
            r_rd    <= 1'b0;
            r_ds    <= 1'b0;
            r_dly   <= '0;
`ifdef RD_ARBITER_TIMEOUT_EN
            r_to    <= '0;
            r_err   <= 1'b0;
`endif
        end else begin
            r_state <= w_nxt;
            r_rd    <= (w_nxt == READ);
            r_ds    <= (w_nxt == DLY);
            r_done  <= (w_nxt == DONE) ? r_gnt : '0;

            if (r_state == IDLE && w_nxt == READ)
                r_gnt <= w_win;
            else if (w_nxt == IDLE)
                r_gnt <= '0;

            if (w_nxt == DONE && r_state != DONE)
                r_ptr <= w_ptr_nxt;

            if (w_nxt == DLY && r_state != DLY)
                r_dly <= 4'(WAIT_CYC - 1);
            else if (r_state == DLY && r_dly != 4'd0)
                r_dly <= r_dly - 4'd1;

`ifdef RD_ARBITER_TIMEOUT_EN
            if (w_nxt == READ)
                r_to <= (r_state == READ) ? r_to + 8'd1 : 8'd1;
            else
                r_to <= '0;
            r_err <= (r_state == READ && w_nxt == DONE);
`endif
        end
    end

    assign gnt  = r_gnt;
    assign done = r_done;
    assign rd   = r_rd;
    assign ds   = r_ds;

endmodule

// File: tb/tb_rd_arbiter.sv
// Randomized self-checking bench for rd_arbiter against a transaction-level model.
module tb_rd_arbiter;

    localparam int NREQ     = 4;
    localparam int WAIT_CYC = 2;
    localparam int TO_CYC   = 15;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [NREQ-1:0] req;
    logic [NREQ-1:0] gnt;
    logic [NREQ-1:0] done;
    logic            ack;
    logic            rd;
    logic            ds;
    logic            err;

    int n_chk = 0;
    int n_err = 0;
    int ptr_m = 0;

    rd_arbiter #(.NREQ(NREQ), .WAIT_CYC(WAIT_CYC), .TO_CYC(TO_CYC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .gnt   (gnt),
        .done  (done),
        .ack   (ack),
        .rd    (rd),
        .ds    (ds),
        .err   (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Round-robin rule: first set bit searching upward from ptr, wrapping.
    function automatic logic [NREQ-1:0] model_pick(input logic [NREQ-1:0] r, input int p);
        logic [NREQ-1:0] w;
        w = '0;
        for (int i = 0; i < NREQ; i++)
            if (w == '0 && r[(p + i) % NREQ]) w[(p + i) % NREQ] = 1'b1;
        return w;
    endfunction

    function automatic int onehot_idx(input logic [NREQ-1:0] w);
        int k;
        k = 0;
        for (int i = 0; i < NREQ; i++) if (w[i]) k = i;
        return k;
    endfunction

    always @(negedge clk)
        if (rst_n === 1'b1) chk("rd_ds_excl", 32'(rd & ds), 0);

    // Called at a negedge with the DUT in IDLE; returns at a negedge in IDLE.
    task automatic txn(input logic [NREQ-1:0] r, input int ackd, input bit drop);
        logic [NREQ-1:0] w;
        ack = 1'b0;
        req = r;
        if (r == '0) begin
            ack = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk("idle_gnt", 32'(gnt), 0);
            chk("idle_rd", 32'(rd), 0);
            return;
        end
        w = model_pick(r, ptr_m);
        for (int k = 0; k <= ackd; k++) begin
            @(negedge clk);
            chk("read_gnt", 32'(gnt), 32'(w));
            chk("read_rd", 32'(rd), 1);
            chk("read_ds", 32'(ds), 0);
            chk("read_done", 32'(done), 0);
            if (k == 0 && drop) req = '0;
            ack = (k == ackd);
        end
        for (int k = 0; k < WAIT_CYC; k++) begin
            @(negedge clk);
            chk("dly_ds", 32'(ds), 1);
            chk("dly_rd", 32'(rd), 0);
            chk("dly_done", 32'(done), 0);
            ack = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        chk("done_pulse", 32'(done), 32'(w));
        chk("done_err", 32'(err), 0);
        chk("done_ds", 32'(ds), 0);
        chk("done_gnt", 32'(gnt), 32'(w));
        ack = 1'($urandom_range(0, 1));
        ptr_m = (onehot_idx(w) + 1) % NREQ;
        @(negedge clk);
        chk("post_gnt", 32'(gnt), 0);
        chk("post_done", 32'(done), 0);
        ack = 1'b0;
    endtask

    initial begin
        logic [NREQ-1:0] w;
        rst_n = 1'b0;
        req   = '0;
        ack   = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_rd", 32'(rd), 0);
        chk("rst_ds", 32'(ds), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_err", 32'(err), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single requester, ack two cycles after rd rises.
        txn(4'b0010, 2, 1'b0);

        // ack pulses while idle must not start anything.
        req = '0;
        for (int k = 0; k < 5; k++) begin
            ack = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk("idle_ack_rd", 32'(rd), 0);
            chk("idle_ack_gnt", 32'(gnt), 0);
        end
        ack = 1'b0;

        // Fair rotation from ptr 0 with all requesters active.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        ptr_m = 0;
        @(negedge clk);
        for (int t = 0; t < 4; t++) txn(4'b1111, 0, 1'b0);

        // Wrap-around: after granting req2, ptr=3 and 0101 goes to requester 0.
        txn(4'b0100, 1, 1'b0);
        txn(4'b0101, 0, 1'b0);
        chk("wrap_ptr_model", 32'(ptr_m), 1);

        // Reset in the middle of DLY abandons the transaction.
        ack = 1'b0;
        req = 4'b0100;
        w = model_pick(req, ptr_m);
        @(negedge clk);
        chk("rstx_gnt", 32'(gnt), 32'(w));
        ack = 1'b1;
        @(negedge clk);
        chk("rstx_ds", 32'(ds), 1);
        rst_n = 1'b0;
        #1;
        chk("rstx_rd0", 32'(rd), 0);
        chk("rstx_ds0", 32'(ds), 0);
        chk("rstx_gnt0", 32'(gnt), 0);
        chk("rstx_done0", 32'(done), 0);
        ack = 1'b0;
        req = '0;
        @(negedge clk);
        rst_n = 1'b1;
        ptr_m = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("rstx_nodone", 32'(done), 0);
            chk("rstx_idle", 32'(gnt), 0);
        end
        txn(4'b1111, 1, 1'b0);

        // Request dropped right after grant still completes.
        txn(4'b1000, 3, 1'b1);

`ifdef RD_ARBITER_TIMEOUT_EN
        ack = 1'b0;
        req = 4'b0010;
        w = model_pick(req, ptr_m);
        for (int k = 0; k < TO_CYC; k++) begin
            @(negedge clk);
            chk("to_rd", 32'(rd), 1);
            chk("to_err_early", 32'(err), 0);
        end
        req = '0;
        @(negedge clk);
        chk("to_err", 32'(err), 1);
        chk("to_done", 32'(done), 32'(w));
        chk("to_rd_off", 32'(rd), 0);
        ptr_m = (onehot_idx(w) + 1) % NREQ;
        @(negedge clk);
        chk("to_idle_gnt", 32'(gnt), 0);
        chk("to_err_clr", 32'(err), 0);
`else
        // Without the timeout READ waits for ack indefinitely.
        txn(4'b0010, TO_CYC + 5, 1'b0);
`endif

        for (int t = 0; t < 40; t++)
            txn(NREQ'($urandom_range(0, 15)), int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)));

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
